// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES stream scheduler.
package aes_sched_pkg;

   localparam int unsigned DATA_W = 128;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWait,
      StStore,
      StError
   } state_t;

   // Watchdog counter width able to hold 0 .. timeout-1.
   function automatic int unsigned wdog_width(input int unsigned timeout);
      return $clog2(timeout);
   endfunction

endpackage

// File: rtl/aes_out_drain.sv
// Output-FIFO drain: pulls a result into the host-facing valid/ready register.
module aes_out_drain (
   input  logic clk,
   input  logic rst,
   input  logic ofifo_full,
   input  logic out_ready,
   output logic ofifo_rd_en,
   output logic out_valid
);

   logic valid_q, valid_d;

   // Reading only while no result is held keeps out_data stable under backpressure.
   always_comb begin
      ofifo_rd_en = ~valid_q & ofifo_full;
      valid_d     = valid_q;
      if (ofifo_rd_en) begin
         valid_d = 1'b1;
      end else if (valid_q & out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;

endmodule

// File: rtl/aes_stream_sched.sv
// Block scheduler: host -> input FIFO -> AES core -> output FIFO -> host,
// with a core watchdog and a completed-block counter.
module aes_stream_sched #(
   parameter int unsigned DATA_W       = 128,
   parameter int unsigned CORE_TIMEOUT = 64,
   parameter int unsigned CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              ififo_wr_en,
   output logic              ififo_rd_en,
   output logic [DATA_W-1:0] ififo_data_in,
   input  logic [DATA_W-1:0] ififo_data_out,
   input  logic              ififo_empty,
   input  logic              ififo_full,
   output logic              ofifo_wr_en,
   output logic              ofifo_rd_en,
   output logic [DATA_W-1:0] ofifo_data_in,
   input  logic [DATA_W-1:0] ofifo_data_out,
   input  logic              ofifo_empty,
   input  logic              ofifo_full,
   output logic              core_start,
   output logic [DATA_W-1:0] core_din,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_dout,
   output logic              busy,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  blk_cnt
);

   import aes_sched_pkg::*;

   localparam int unsigned WDOG_W = wdog_width(CORE_TIMEOUT);

   state_t            state_q, state_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic              err_q, err_d;
   logic              wdog_expired;

   assign wdog_expired = (wdog_q == WDOG_W'(CORE_TIMEOUT - 1));

   // Writes need an empty FIFO and reads a full one, so they never coincide.
   assign in_ready      = ~rst & ififo_empty;
   assign ififo_wr_en   = in_valid & in_ready;
   assign ififo_data_in = in_data;
   assign core_din      = ififo_data_out;
   assign ofifo_data_in = res_q;
   assign out_data      = ofifo_data_out;
   assign err_timeout   = err_q;
   assign blk_cnt       = blk_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (ififo_rd_en) state_d = StLoad;
         StLoad:  state_d = StWait;
         StWait: begin
            if (core_done) begin
               state_d = StStore;
            end else if (wdog_expired) begin
               state_d = StError;
            end
         end
         StStore: if (ofifo_wr_en) state_d = StIdle;
         StError: state_d = StError;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ififo_rd_en = 1'b0;
      ofifo_wr_en = 1'b0;
      core_start  = 1'b0;
      unique case (state_q)
         StIdle:  ififo_rd_en = enable & ififo_full & ~err_q;
         StLoad:  core_start  = 1'b1;
         StStore: ofifo_wr_en = ofifo_empty;
         default: ;
      endcase
      busy = (state_q != StIdle);
   end

   // Datapath registers; core_done outside WAIT is deliberately ignored.
   always_comb begin
      wdog_d    = wdog_q;
      res_d     = res_q;
      blk_cnt_d = blk_cnt_q;
      err_d     = err_q;
      unique case (state_q)
         StLoad: wdog_d = '0;
         StWait: begin
            if (core_done) begin
               res_d = core_dout;
            end else if (wdog_expired) begin
               err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StStore: if (ofifo_wr_en) blk_cnt_d = blk_cnt_q + 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q    <= '0;
         res_q     <= '0;
         blk_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         res_q     <= res_d;
         blk_cnt_q <= blk_cnt_d;
         err_q     <= err_d;
      end
   end

   aes_out_drain u_out_drain (
      .clk         (clk),
      .rst         (rst),
      .ofifo_full  (ofifo_full),
      .out_ready   (out_ready),
      .ofifo_rd_en (ofifo_rd_en),
      .out_valid   (out_valid)
   );

endmodule

// File: tb/tb_aes_stream_sched.sv
// Bench for aes_stream_sched with single-entry FIFO models and a latency-programmable core.
module tb_aes_stream_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         ififo_wr_en, ififo_rd_en, ififo_empty, ififo_full;
   logic [127:0] ififo_data_in, ififo_data_out;
   logic         ofifo_wr_en, ofifo_rd_en, ofifo_empty, ofifo_full;
   logic [127:0] ofifo_data_in, ofifo_data_out;
   logic         core_start;
   logic [127:0] core_din;
   logic         core_done = 1'b0;
   logic [127:0] core_dout = '0;
   logic         busy, err_timeout;
   logic [31:0]  blk_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_stream_sched #(
      .DATA_W       (128),
      .CORE_TIMEOUT (64),
      .CNT_W        (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .ififo_wr_en    (ififo_wr_en),
      .ififo_rd_en    (ififo_rd_en),
      .ififo_data_in  (ififo_data_in),
      .ififo_data_out (ififo_data_out),
      .ififo_empty    (ififo_empty),
      .ififo_full     (ififo_full),
      .ofifo_wr_en    (ofifo_wr_en),
      .ofifo_rd_en    (ofifo_rd_en),
      .ofifo_data_in  (ofifo_data_in),
      .ofifo_data_out (ofifo_data_out),
      .ofifo_empty    (ofifo_empty),
      .ofifo_full     (ofifo_full),
      .core_start     (core_start),
      .core_din       (core_din),
      .core_done      (core_done),
      .core_dout      (core_dout),
      .busy           (busy),
      .err_timeout    (err_timeout),
      .blk_cnt        (blk_cnt)
   );

   // Single-entry FIFO models with registered outputs.
   logic         if_full = 1'b0, of_full = 1'b0;
   logic [127:0] if_mem, if_dout = '0, of_mem, of_dout = '0;
   assign ififo_full     = if_full;
   assign ififo_empty    = ~if_full;
   assign ififo_data_out = if_dout;
   assign ofifo_full     = of_full;
   assign ofifo_empty    = ~of_full;
   assign ofifo_data_out = of_dout;

   always @(posedge clk) begin
      if (rst) begin
         if_full <= 1'b0; if_dout <= '0; of_full <= 1'b0; of_dout <= '0;
      end else begin
         if (ififo_wr_en) begin if_mem <= ififo_data_in; if_full <= 1'b1; end
         if (ififo_rd_en) begin if_dout <= if_mem; if_full <= 1'b0; end
         if (ofifo_wr_en) begin of_mem <= ofifo_data_in; of_full <= 1'b1; end
         if (ofifo_rd_en) begin of_dout <= of_mem; of_full <= 1'b0; end
      end
   end

   // Core model: done arrives core_lat cycles after start, result from resp_q.
   logic         core_hold = 1'b0;
   int           core_lat  = 1;
   int           core_cnt  = 0;
   logic         core_busy = 1'b0;
   logic [127:0] core_din_seen = '0;
   logic [127:0] resp_q[$];

   function automatic logic [127:0] pop_resp();
      if (resp_q.size() != 0) return resp_q.pop_front();
      return '0;
   endfunction

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (rst) begin
         core_busy <= 1'b0;
      end else if (core_start) begin
         core_din_seen <= core_din;
         if (core_lat <= 1 && !core_hold) begin
            core_done <= 1'b1;
            core_dout <= pop_resp();
         end else begin
            core_busy <= 1'b1;
            core_cnt  <= core_lat - 1;
         end
      end else if (core_busy && !core_hold) begin
         if (core_cnt <= 1) begin
            core_done <= 1'b1;
            core_dout <= pop_resp();
            core_busy <= 1'b0;
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   // Event monitors sampled mid-cycle.
   int           rd_cyc = -1, st_cyc = -1, ow_cyc = -1;
   int           rd_cnt = 0, ow_cnt = 0, viol = 0;
   logic [127:0] out_q[$];

   always @(negedge clk) begin
      if (ififo_rd_en) begin rd_cyc = cyc; rd_cnt++; end
      if (core_start) st_cyc = cyc;
      if (ofifo_wr_en) begin ow_cyc = cyc; ow_cnt++; end
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (ififo_wr_en && ififo_rd_en) viol++;
      if (ofifo_wr_en && ofifo_rd_en) viol++;
      if (ififo_wr_en && if_full) viol++;
      if (ofifo_wr_en && of_full) viol++;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; core_hold = 1'b0; enable = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      resp_q.delete();
      out_q.delete();
      #1;
   endtask

   task automatic send(input logic [127:0] d, output int hs);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin tick(); n++; end
      if (!in_ready) chk("send_timeout", 128'd0, 128'd1);
      hs = cyc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int k = 0;
      while (out_q.size() < n && k < 300) begin tick(); k++; end
      chk("out_count", out_q.size(), n);
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] resp;
      int           lat;
      int           exp_valid;  // handshake -> out_valid
      int           exp_owr;    // handshake -> ofifo_wr_en
      logic [31:0]  exp_cnt;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int hs, hb, n, c, rdc, owc;
      vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF,
                  10, 15, 13, 32'd1};
      vecs[1] = '{128'h0123456789ABCDEF0123456789ABCDEF, 128'hFEDCBA9876543210FEDCBA9876543210,
                  1, 6, 4, 32'd2};
      vecs[2] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h00000000000000000000000000000000,
                  3, 8, 6, 32'd3};
      vecs[3] = '{128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A,
                  20, 25, 23, 32'd4};

      // Reset state.
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_core_start", core_start, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Single blocks at several core latencies.
      for (int i = 0; i < 4; i++) begin
         core_lat = vecs[i].lat;
         resp_q.push_back(vecs[i].resp);
         send(vecs[i].din, hs);
         n = 0;
         while (!out_valid && n < 100) begin tick(); n++; end
         chk($sformatf("v%0d_valid_lat", i), cyc - hs, vecs[i].exp_valid);
         chk($sformatf("v%0d_out_data", i), out_data, vecs[i].resp);
         chk($sformatf("v%0d_rd_lat", i), rd_cyc - hs, 1);
         chk($sformatf("v%0d_start_lat", i), st_cyc - hs, 2);
         chk($sformatf("v%0d_owr_lat", i), ow_cyc - hs, vecs[i].exp_owr);
         chk($sformatf("v%0d_core_din", i), core_din_seen, vecs[i].din);
         chk($sformatf("v%0d_blk_cnt", i), blk_cnt, vecs[i].exp_cnt);
         tick();
         tick();
      end

      // Back-to-back blocks overlap with core processing.
      do_reset();
      core_lat = 10;
      resp_q.push_back(128'h11111111222222223333333344444444);
      resp_q.push_back(128'h55555555666666667777777788888888);
      send(128'hAAAA0000AAAA0000AAAA0000AAAA0000, hs);
      send(128'hBBBB0000BBBB0000BBBB0000BBBB0000, hb);
      chk("b2b_accept_gap", hb - hs, 2);
      wait_out(2);
      chk("b2b_out0", out_q[0], 128'h11111111222222223333333344444444);
      chk("b2b_out1", out_q[1], 128'h55555555666666667777777788888888);
      chk("b2b_blk_cnt", blk_cnt, 2);

      // Output backpressure: four blocks with the host not accepting.
      do_reset();
      core_lat  = 2;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) resp_q.push_back(128'hC0 + 128'(i));
      for (int i = 0; i < 4; i++) send(128'h100 + 128'(i), hs);
      for (int i = 0; i < 30; i++) tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 128'hC0);
      chk("bp_ofifo_full", of_full, 1);
      chk("bp_busy", busy, 1);
      chk("bp_no_owr", ofifo_wr_en, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_blk_cnt", blk_cnt, 2);
      chk("bp_none_taken", out_q.size(), 0);
      tick();
      chk("bp_out_data_held", out_data, 128'hC0);
      out_ready = 1'b1;
      wait_out(4);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_out%0d", i), out_q[i], 128'hC0 + 128'(i));
      chk("bp_blk_cnt_end", blk_cnt, 4);

      // Watchdog timeout with core_done withheld.
      do_reset();
      core_lat  = 5;
      core_hold = 1'b1;
      resp_q.push_back(128'hBAD);
      send(128'h1234, hs);
      n = 0;
      while (!err_timeout && n < 200) begin tick(); n++; end
      chk("to_cycles_in_wait", cyc - (st_cyc + 1), 64);
      chk("to_busy", busy, 1);
      rdc = rd_cnt;
      owc = ow_cnt;
      send(128'h5678, hs);
      for (int i = 0; i < 10; i++) tick();
      chk("to_no_rd", rd_cnt, rdc);
      chk("to_in_ready", in_ready, 0);
      core_hold = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("to_err_sticky", err_timeout, 1);
      chk("to_no_owr", ow_cnt, owc);
      chk("to_blk_cnt", blk_cnt, 0);
      do_reset();
      chk("to_err_cleared", err_timeout, 0);
      chk("to_busy_cleared", busy, 0);

      // enable=0 holds a full input FIFO; enable=1 reads it immediately.
      do_reset();
      enable   = 1'b0;
      core_lat = 3;
      resp_q.push_back(128'hE1E1);
      rdc = rd_cnt;
      send(128'hE0E0, hs);
      for (int i = 0; i < 5; i++) tick();
      chk("en_no_rd", rd_cnt, rdc);
      chk("en_in_ready", in_ready, 0);
      chk("en_busy", busy, 0);
      enable = 1'b1;
      c = cyc;
      tick();
      chk("en_rd_cycle", rd_cyc, c);
      wait_out(1);
      chk("en_out", out_q[0], 128'hE1E1);
      chk("en_blk_cnt", blk_cnt, 1);

      // Reset while waiting on the core.
      do_reset();
      core_lat = 2;
      resp_q.push_back(128'h77);
      send(128'h66, hs);
      wait_out(1);
      chk("rw_blk_cnt_pre", blk_cnt, 1);
      core_hold = 1'b1;
      send(128'h88, hs);
      for (int i = 0; i < 5; i++) tick();
      chk("rw_busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      chk("rw_in_ready_in_rst", in_ready, 0);
      tick();
      rst = 1'b0;
      core_hold = 1'b0;
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_blk_cnt", blk_cnt, 0);
      chk("rw_err", err_timeout, 0);
      chk("rw_out_valid", out_valid, 0);
      chk("rw_core_start", core_start, 0);
      chk("rw_ififo_rd", ififo_rd_en, 0);
      chk("rw_ofifo_wr", ofifo_wr_en, 0);
      chk("rw_in_ready", in_ready, 1);

      chk("fifo_protocol_violations", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
